// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 valid-region convolution; define CONV_ABS_EN for |sum| output.
module conv3x3_stream #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        run,
  input  logic [17:0] filter_weights,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        frame_done,
  output logic        err_tlast
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state;
  logic [17:0] w_q;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0] lb0 [IMG_W];
  logic [7:0] lb1 [IMG_W];
  logic [7:0] win [9];
  logic [7:0] nw [9];
  logic signed [13:0] sum;
  logic [7:0] sat;
  logic hs_in, hs_out, last_px;
`ifdef CONV_ABS_EN
  logic signed [13:0] mag;
`endif
  assign s_axis_tready = state == STREAM && run && (!m_axis_tvalid || m_axis_tready);
  assign hs_in = s_axis_tvalid && s_axis_tready;
  assign hs_out = m_axis_tvalid && m_axis_tready;
  assign last_px = row == ROW_LAST && col == COL_LAST;
  // window after this handshake's shift: column 2 is the newest column
  always_comb begin
    nw[0] = win[1];
    nw[1] = win[2];
    nw[2] = lb1[col];
    nw[3] = win[4];
    nw[4] = win[5];
    nw[5] = lb0[col];
    nw[6] = win[7];
    nw[7] = win[8];
    nw[8] = s_axis_tdata;
    sum = '0;
    for (int k = 0; k < 9; k++)
      sum = sum + $signed({{12{w_q[2*k+1]}}, w_q[2*k +: 2]}) * $signed({6'd0, nw[k]});
`ifdef CONV_ABS_EN
    mag = sum[13] ? -sum : sum;
    sat = mag > 14'sd255 ? 8'hFF : mag[7:0];
`else
    sat = sum[13] ? 8'h00 : (sum > 14'sd255 ? 8'hFF : sum[7:0]);
`endif
  end
  always_ff @(posedge clk) begin
    if (hs_in) begin
      lb1[col] <= lb0[col];
      lb0[col] <= s_axis_tdata;
      for (int k = 0; k < 9; k++) win[k] <= nw[k];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w_q <= '0;
      col <= '0;
      row <= '0;
      err_tlast <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= !start && state == DRAIN && hs_out && m_axis_tlast;
      if (start) begin
        state <= STREAM;
        w_q <= filter_weights;
        col <= '0;
        row <= '0;
        err_tlast <= 1'b0;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast <= 1'b0;
      end else begin
        if (hs_in) begin
          col <= col == COL_LAST ? '0 : col + 1'b1;
          if (col == COL_LAST) row <= last_px ? '0 : row + 1'b1;
          if (last_px) begin
            state <= DRAIN;
            if (!s_axis_tlast) err_tlast <= 1'b1;
          end else if (s_axis_tlast) err_tlast <= 1'b1;
        end
        if (hs_in && row >= RW'(2) && col >= CW'(2)) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata <= sat;
          m_axis_tlast <= last_px;
        end else if (hs_out) begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast <= 1'b0;
        end
        if (state == DRAIN && hs_out && m_axis_tlast) state <= IDLE;
      end
    end
  end
endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming 3x3 convolution engine that sits directly downstream of the AXI-Lite control block. It takes the `start`/`run` strobes and the 18-bit packed filter weights from that block, and consumes a raster-order 8-bit pixel AXI-Stream. It emits a "valid"-region (no padding) filtered AXI-Stream. At end of frame it pulses `frame_done`, which is wired back to the control block's `tlast` input.

## Interface
- `IMG_W`, default 64: frame width in pixels; must be ≥ 3.
- `IMG_H`, default 64: frame height in pixels; must be ≥ 3.
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle pulse that arms a new frame.
- `run`, in, 1: level; the controller is in its RUN state.
- `filter_weights`, in, 18: nine 2-bit two's-complement weights.
  - Weight k occupies bits [2k+1:2k]; k = 3*row + col; k=0 is the top-left (oldest) window position.
- `s_axis_tdata`, in, 8: input pixel, unsigned.
- `s_axis_tvalid`, in, 1: input valid.
- `s_axis_tready`, out, 1: input ready.
- `s_axis_tlast`, in, 1: end-of-frame marker; checked, never trusted.
- `m_axis_tdata`, out, 8: output pixel.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tready`, in, 1: output ready.
- `m_axis_tlast`, out, 1: asserted with the final output pixel.
- `frame_done`, out, 1: one-cycle pulse, to the controller's `tlast`.
- `err_tlast`, out, 1: sticky; set when `s_axis_tlast` does not match the expected final input pixel.

## Operation
- **FSM states:** IDLE, STREAM, DRAIN.
- **IDLE → STREAM** on `start`:
  - latch `filter_weights` into `w_q`;
  - clear the row/column counters and `err_tlast`.
- **`start` in STREAM or DRAIN:** same action as in IDLE (frame restarts). The pending output register is dropped: `m_axis_tvalid` goes to 0.
- **STREAM:** `s_axis_tready = run && (!m_axis_tvalid || m_axis_tready)`. It is 0 in IDLE and DRAIN.
- **Each input handshake:**
  - the pixel shifts into two line buffers (depth `IMG_W`) and the 3x3 window registers;
  - col increments and wraps at `IMG_W-1`; row increments on the wrap.
- **Output generation:** a handshake at (row ≥ 2, col ≥ 2) computes sum = Σ w_k · p_k.
  - Each product is a signed 2-bit weight times a 9-bit zero-extended pixel.
  - The accumulator is 14-bit signed; its range is −4590..+2295 and it never overflows.
- **Saturation to 8 bits:** sum < 0 → 0; sum > 255 → 255; otherwise sum[7:0].
- **Output count:** (`IMG_W`−2)·(`IMG_H`−2) pixels, in raster order.
- **Last input handshake** (row `IMG_H-1`, col `IMG_W-1`):
  - if `s_axis_tlast` = 0 there, set `err_tlast`;
  - `s_axis_tlast` = 1 on any earlier pixel also sets `err_tlast`, and that tlast is otherwise ignored;
  - go to DRAIN.
- **DRAIN → IDLE** on the `m_axis` handshake carrying `m_axis_tlast`. `frame_done` pulses in the next cycle.
- **`run` deasserted mid-frame:** input is stalled; state and counters are held.

## Timing
- **Reset values:** `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `frame_done`=0, `err_tlast`=0. State = IDLE, counters = 0, `w_q` = 0. Line-buffer contents are don't-care.
- **Latency:** the output appears in `m_axis` registers 1 cycle after the input handshake that completes its window.
- **Output hold:** `m_axis_tvalid`/`tdata`/`tlast` stay stable until the handshake.
- **Throughput:** one pixel per cycle while `m_axis_tready`=1 (simultaneous accept-and-reload allowed).
- **`frame_done` timing:** exactly one cycle, one cycle after the final output handshake. The controller sees it while still in RUN.
- **Weight latching:** weights are sampled only on `start`; `filter_weights` changes mid-frame have no effect.
- **`rst` mid-frame:** returns to reset values at the next edge. Partial frames are discarded; no `frame_done`.

## Configuration
- **`CONV_ABS_EN` defined:** output = min(|sum|, 255), for edge-detection kernels.
- **`CONV_ABS_EN` undefined:** clamp negatives to 0 (default behaviour above).
- Latency, handshakes and the FSM are identical in both builds.

## Test plan
- **Identity kernel:** `IMG_W`=5, `IMG_H`=4, weights 18'h00100, pixel value = 5·row+col, `m_axis_tready`=1.
  - → outputs 6,7,8,11,12,13;
  - `m_axis_tlast` on 13;
  - `frame_done` 1 cycle later; `err_tlast`=0.
- **Saturation:** all pixels 200, weights 18'h15555 (all +1) → every output 255. Weights 18'h3FFFF (all −1):
  - → 0 without `CONV_ABS_EN`;
  - → 255 with `CONV_ABS_EN`.
- **Backpressure:** identity frame with `m_axis_tready` toggling 1-0-1-0 → same 6 values, no loss or duplication; `tdata` stable while stalled; `s_axis_tready`=0 whenever output is held.
- **tlast errors:**
  - `s_axis_tlast` on pixel 7 → `err_tlast`=1; frame still completes with 6 outputs and `frame_done`;
  - `s_axis_tlast` missing on pixel 19 → `err_tlast`=1.
- **Weights latched on `start`:** change `filter_weights` mid-frame from 18'h00100 to 18'h3FFFF → outputs still follow the identity kernel.
- **Reset and restart:** `rst` after 9 input pixels → all outputs at reset values next cycle. A new `start` plus a full frame → correct 6 outputs.
